// File: rtl/add_mult_sfr.sv
// Repeated-addition multiplier SFR: latches A and B on start, then adds A into
// P once per cycle, B times, giving P = A*B mod 2^SIZE with a sticky carry flag.
module add_mult_sfr #(
    parameter int SIZE  = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             start,
    input  logic [SIZE-1:0]  A,
    input  logic [CNT_W-1:0] B,
    output logic [SIZE-1:0]  P,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [SIZE-1:0]  a_reg;
    logic [CNT_W-1:0] cnt;
    logic [SIZE:0]    sum;

    assign sum  = {1'b0, P} + {1'b0, a_reg};
    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // clr overrides everything, including a start arriving in the same cycle.
    always_comb begin
        next_state = state;
        if (clr) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) next_state = RUN;
                RUN:     if (cnt == '0) next_state = DONE;
                DONE:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            P     <= '0;
            ovf   <= 1'b0;
            cnt   <= '0;
            a_reg <= '0;
        end else if (clr) begin
            P   <= '0;
            ovf <= 1'b0;
            cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= A;
                        cnt   <= B;
                        P     <= '0;
                        ovf   <= 1'b0;
                    end
                end
                RUN: begin
                    if (cnt != '0) begin
                        P   <= sum[SIZE-1:0];
                        ovf <= ovf | sum[SIZE];
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_add_mult_sfr.sv
// Self-checking bench for add_mult_sfr: directed scenarios plus randomized
// operations compared against a plain-arithmetic product model.
module tb_add_mult_sfr;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        start = 1'b0;
    logic [31:0] A = '0;
    logic [7:0]  B = '0;
    logic [31:0] P;
    logic        busy;
    logic        done;
    logic        ovf;

    int n_cmp  = 0;
    int n_fail = 0;

    add_mult_sfr #(.SIZE(32), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .clr(clr), .start(start),
        .A(A), .B(B), .P(P), .busy(busy), .done(done), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Reference: the exact product; any carry during accumulation means it exceeded 32 bits.
    function automatic void model(input logic [31:0] a, input logic [7:0] b,
                                  output logic [31:0] p, output logic o);
        logic [63:0] prod;
        prod = 64'(a) * 64'(b);
        p = prod[31:0];
        o = (prod[63:32] != 32'd0);
    endfunction

    // Starts one operation from IDLE and watches it to completion, scrambling A/B meanwhile.
    task automatic run_op(input logic [31:0] a, input logic [7:0] b,
                          output int busy_n, output int done_n, output int done_k,
                          output logic timed_out);
        int k;
        @(negedge clk);
        A = a; B = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_n = 0; done_n = 0; done_k = -1; k = 0;
        while (busy && k < 300) begin
            busy_n++;
            if (done) begin
                done_n++;
                done_k = k;
            end
            A = $urandom;
            B = 8'($urandom);
            @(negedge clk);
            k++;
        end
        timed_out = busy;
    endtask

    task automatic check_op(input string name, input logic [31:0] a, input logic [7:0] b);
        int bn, dn, dk;
        logic to;
        logic [31:0] ep;
        logic eo;
        model(a, b, ep, eo);
        run_op(a, b, bn, dn, dk, to);
        n_cmp++;
        if (to !== 1'b0) begin n_fail++; $display("[TB] FAIL %s timeout: busy stuck high", name); end
        n_cmp++;
        if (P !== ep) begin n_fail++; $display("[TB] FAIL %s P: got %h expected %h", name, P, ep); end
        n_cmp++;
        if (ovf !== eo) begin n_fail++; $display("[TB] FAIL %s ovf: got %b expected %b", name, ovf, eo); end
        n_cmp++;
        if (bn !== int'(b) + 2) begin n_fail++; $display("[TB] FAIL %s busy cycles: got %0d expected %0d", name, bn, int'(b) + 2); end
        n_cmp++;
        if (dn !== 1 || dk !== int'(b) + 1) begin
            n_fail++;
            $display("[TB] FAIL %s done: got %0d pulses at %0d expected 1 at %0d", name, dn, dk, int'(b) + 1);
        end
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if (P !== 32'd0 || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset: got P=%h busy=%b done=%b ovf=%b expected all 0", P, busy, done, ovf);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || P !== 32'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_idle: got busy=%b P=%h expected 0/0", busy, P);
        end
    endtask

    task automatic test_basic();
        check_op("basic_7x5", 32'd7, 8'd5);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (P !== 32'd35 || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL basic_hold: got P=%h busy=%b expected 23/0", P, busy);
        end
    endtask

    task automatic test_zero_count();
        check_op("zero_count", 32'h1234, 8'd0);
    endtask

    task automatic test_overflow();
        check_op("ovf_set", 32'h8000_0000, 8'd3);
        check_op("ovf_clear", 32'd1, 8'd1);
    endtask

    task automatic test_start_while_busy();
        int k, dn;
        @(negedge clk);
        A = 32'd3; B = 8'd4; start = 1'b1;
        @(negedge clk);
        A = 32'd9; B = 8'd9;
        k = 0; dn = 0;
        while (busy && k < 50) begin
            if (done) dn++;
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        n_cmp++;
        if (P !== 32'd12) begin n_fail++; $display("[TB] FAIL busy_start P: got %h expected %h", P, 32'd12); end
        n_cmp++;
        if (dn !== 1) begin n_fail++; $display("[TB] FAIL busy_start done pulses: got %0d expected 1", dn); end
        n_cmp++;
        if (k !== 6) begin n_fail++; $display("[TB] FAIL busy_start busy cycles: got %0d expected 6", k); end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || P !== 32'd12) begin
            n_fail++;
            $display("[TB] FAIL busy_start ignored: got busy=%b P=%h expected 0/c", busy, P);
        end
    endtask

    task automatic test_async_reset();
        int dn;
        @(negedge clk);
        A = 32'd5; B = 8'd200; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dn = 0;
        repeat (20) begin
            if (done) dn++;
            @(negedge clk);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (P !== 32'd0 || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL async_rst: got P=%h busy=%b done=%b ovf=%b expected all 0", P, busy, done, ovf);
        end
        n_cmp++;
        if (dn !== 0) begin n_fail++; $display("[TB] FAIL async_rst done: got %0d pulses expected 0", dn); end
        @(negedge clk);
        rst = 1'b0;
        check_op("after_rst", 32'd6, 8'd2);
    endtask

    task automatic test_clear();
        int dn;
        @(negedge clk);
        A = 32'd5; B = 8'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dn = 0;
        repeat (3) begin
            if (done) dn++;
            @(negedge clk);
        end
        clr = 1'b1; start = 1'b1;
        @(negedge clk);
        clr = 1'b0; start = 1'b0;
        n_cmp++;
        if (P !== 32'd0 || busy !== 1'b0 || ovf !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL clr: got P=%h busy=%b ovf=%b done=%b expected all 0", P, busy, ovf, done);
        end
        repeat (12) begin
            if (done || busy) dn++;
            @(negedge clk);
        end
        n_cmp++;
        if (dn !== 0) begin n_fail++; $display("[TB] FAIL clr activity: got %0d busy/done cycles expected 0", dn); end
        check_op("after_clr", 32'd5, 8'd10);
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [7:0]  b;
        for (int i = 0; i < 20; i++) begin
            a = (i % 2 == 0) ? $urandom : 32'($urandom_range(0, 1000));
            b = 8'($urandom_range(0, 255));
            check_op($sformatf("rand%0d", i), a, b);
        end
    endtask

    task automatic test_back_to_back();
        check_op("b2b_first", 32'hFFFF_FFFF, 8'd2);
        check_op("b2b_second", 32'd11, 8'd13);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_count();
        test_overflow();
        test_start_while_busy();
        test_async_reset();
        test_clear();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
